// File: rtl/pixel_packer_pkg.sv
// Shared definitions for the pixel packer: default geometry, output FSM states,
// and the fill-index helper.
`timescale 1ns/1ps
package pixel_packer_pkg;

   localparam int DEF_PIX_W = 8;
   localparam int DEF_PIX_N = 96;
   localparam int DEF_IDX_W = 7;
   localparam int DEF_CNT_W = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_e;

   // True when idx addresses the final slot of a bank of pix_n pixels.
   function automatic logic is_last_slot(input logic [DEF_IDX_W-1:0] idx, input int pix_n);
      return idx == DEF_IDX_W'(pix_n - 1);
   endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// Bundles the pixel stream, the packed-word handshake and the stall statistic.
`timescale 1ns/1ps
interface pixel_packer_if #(
   parameter int PIX_W = pixel_packer_pkg::DEF_PIX_W,
   parameter int PIX_N = pixel_packer_pkg::DEF_PIX_N,
   parameter int CNT_W = pixel_packer_pkg::DEF_CNT_W
);
   logic                   s_valid;
   logic [PIX_W-1:0]       s_data;
   logic                   s_sof;
   logic                   s_ready;
   logic                   request;
   logic                   ready;
   logic [PIX_W*PIX_N-1:0] o_data;
   logic [CNT_W-1:0]       stall_cnt;

   modport master (
      output s_valid, s_data, s_sof, request,
      input  s_ready, ready, o_data, stall_cnt
   );

   modport slave (
      input  s_valid, s_data, s_sof, request,
      output s_ready, ready, o_data, stall_cnt
   );
endinterface

// File: rtl/pixel_packer_bank.sv
// pixel_bank: one PIX_N x PIX_W register bank with indexed write and a
// full-width parallel read.
`timescale 1ns/1ps
module pixel_bank #(
   parameter int PIX_W = pixel_packer_pkg::DEF_PIX_W,
   parameter int PIX_N = pixel_packer_pkg::DEF_PIX_N,
   parameter int IDX_W = pixel_packer_pkg::DEF_IDX_W
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [IDX_W-1:0]       widx,
   input  logic [PIX_W-1:0]       wdata,
   output logic [PIX_W*PIX_N-1:0] rd_data
);
   logic [PIX_W*PIX_N-1:0] data_q, data_d;

   // Contents need no reset: a bank is only read after every slot is rewritten.
   always_comb begin
      data_d = data_q;
      if (we && (widx < IDX_W'(PIX_N))) begin
         data_d[widx*PIX_W +: PIX_W] = wdata;
      end else begin
         data_d = data_q;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign rd_data = data_q;
endmodule

// File: rtl/pixel_packer.sv
// pixel_packer: packs a 1-pixel/cycle stream into a double-buffered wide word
// and serves it with a one-cycle ready pulse. Optional: PIXEL_PACKER_STATS_EN.
`timescale 1ns/1ps
module pixel_packer
   import pixel_packer_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W,
   parameter int PIX_N = DEF_PIX_N,
   parameter int IDX_W = DEF_IDX_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic           clk,
   input logic           rst,
   pixel_packer_if.slave bus
);
   localparam int W = PIX_W * PIX_N;

   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   state_e           state_q, state_d;
   logic             ready_q, ready_d;
   logic [W-1:0]     o_data_q, o_data_d;

   logic             s_ready_s;
   logic             accept_s;
   logic [IDX_W-1:0] widx_s;
   logic [W-1:0]     rd_data0_s, rd_data1_s;

   assign s_ready_s = ~full_q[wr_bank_q];
   assign accept_s  = bus.s_valid & s_ready_s;
   assign widx_s    = bus.s_sof ? '0 : idx_q;

   pixel_bank #(.PIX_W(PIX_W), .PIX_N(PIX_N), .IDX_W(IDX_W)) u_bank0 (
      .clk     (clk),
      .we      (accept_s & ~wr_bank_q),
      .widx    (widx_s),
      .wdata   (bus.s_data),
      .rd_data (rd_data0_s)
   );

   pixel_bank #(.PIX_W(PIX_W), .PIX_N(PIX_N), .IDX_W(IDX_W)) u_bank1 (
      .clk     (clk),
      .we      (accept_s & wr_bank_q),
      .widx    (widx_s),
      .wdata   (bus.s_data),
      .rd_data (rd_data1_s)
   );

   // Fill and serve never touch the same bank's flag in one cycle: filling needs
   // it clear, serving needs it set.
   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      idx_d     = idx_q;
      state_d   = state_q;
      ready_d   = 1'b0;
      o_data_d  = o_data_q;

      if (accept_s) begin
         if (bus.s_sof) begin
            idx_d = IDX_W'(1);
         end else if (is_last_slot(idx_q, PIX_N)) begin
            idx_d             = '0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end else begin
         idx_d = idx_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.request && full_q[rd_bank_q]) begin
               o_data_d          = rd_bank_q ? rd_data1_s : rd_data0_s;
               ready_d           = 1'b1;
               full_d[rd_bank_q] = 1'b0;
               rd_bank_d         = ~rd_bank_q;
               state_d           = ST_SERVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SERVE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         idx_q     <= '0;
         state_q   <= ST_IDLE;
         ready_q   <= 1'b0;
         o_data_q  <= '0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         idx_q     <= idx_d;
         state_q   <= state_d;
         ready_q   <= ready_d;
         o_data_q  <= o_data_d;
      end
   end

   assign bus.s_ready = s_ready_s;
   assign bus.ready   = ready_q;
   assign bus.o_data  = o_data_q;

`ifdef PIXEL_PACKER_STATS_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   // Saturating count of cycles where the source is held off.
   always_comb begin
      if (bus.s_valid && !s_ready_s && (stall_q != {CNT_W{1'b1}})) begin
         stall_d = stall_q + CNT_W'(1);
      end else begin
         stall_d = stall_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign bus.stall_cnt = stall_q;
`else
   assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// Directed scoreboard bench for pixel_packer: the driver models packing and
// queues expected words; a monitor pops and compares on every ready pulse.
`timescale 1ns/1ps
module tb_pixel_packer;
   localparam int PW = 8;
   localparam int PN = 96;
   localparam int W  = PW * PN;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pixel_packer_if bus ();
   pixel_packer u_dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   int stalls = 0;
   time last_acc_time = 0;
   time last_pulse_time = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] part;
   int           pidx = 0;
   logic         prev_ready = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      part = '0;
      pidx = 0;
   endtask

   task automatic send(input logic [7:0] v, input logic sof);
      int   waits = 0;
      logic acc   = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = v;
      bus.s_sof   = sof;
      forever begin
         @(negedge clk);
         if (bus.s_ready === 1'b1) begin
            acc = 1'b1;
            break;
         end
         stalls++;
         waits++;
         if (waits > 400) begin
            total++;
            bad++;
            $display("FAIL send_timeout act=stalled exp=accepted");
            break;
         end
      end
      if (acc) begin
         if (sof) pidx = 0;
         part[pidx*PW +: PW] = v;
         pidx++;
         if (pidx == PN) begin
            exp_q.push_back(part);
            pidx = 0;
         end
         last_acc_time = $time;
      end
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_sof   = 1'b0;
   endtask

   task automatic wait_pulses(input string name, input int n, input int budget);
      int c = 0;
      while (pulses < n && c < budget) begin
         @(posedge clk);
         c++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk(name, pulses, n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Scoreboard monitor: every ready pulse must match the oldest queued word.
   always @(negedge clk) begin
      if (rst) begin
         prev_ready <= 1'b0;
      end else begin
         if (bus.ready === 1'b1) begin
            pulses++;
            last_pulse_time = $time;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL word_unexpected act=%h exp=none", bus.o_data);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               if (bus.o_data !== e) begin
                  bad++;
                  $display("FAIL word act=%h exp=%h", bus.o_data, e);
               end
            end
            total++;
            if (prev_ready) begin
               bad++;
               $display("FAIL ready_adjacent act=1 exp=0");
            end
            total++;
            if (bus.s_ready !== 1'b1) begin
               bad++;
               $display("FAIL s_ready_on_pulse act=%b exp=1", bus.s_ready);
            end
         end
         prev_ready <= (bus.ready === 1'b1);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_sof   = 1'b0;
      bus.request = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
      chk("rst_ready", 32'(bus.ready), 32'd0);
      chk("rst_o_data_lo", bus.o_data[31:0], 32'd0);
      chk("rst_stall", 32'(bus.stall_cnt), 32'd0);

      // 1: single word, request held high
      bus.request = 1'b1;
      stalls = 0;
      for (int k = 0; k < PN; k++) send(8'(k), 1'b0);
      wait_pulses("t1_pulses", 1, 20);
      chk("t1_latency", 32'(last_pulse_time - last_acc_time), 32'd20);
      chk("t1_stalls", stalls, 0);
      chk("t1_slot0", 32'(bus.o_data[7:0]), 32'h00);
      chk("t1_slot95", 32'(bus.o_data[95*8 +: 8]), 32'h5F);

      // 2: both banks fill with request low, then drain
      bus.request = 1'b0;
      stalls = 0;
      for (int i = 0; i < 192; i++) send(8'(i) ^ 8'h5A, 1'b0);
      chk("t2_stalls_pre", stalls, 0);
      @(negedge clk);
      chk("t2_s_ready_full", 32'(bus.s_ready), 32'd0);
      fork
         begin
            for (int i = 192; i < 250; i++) send(8'(i) ^ 8'h5A, 1'b0);
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            chk("t2_held_pulses", pulses, 1);
            chk("t2_held_s_ready", 32'(bus.s_ready), 32'd0);
            bus.request = 1'b1;
         end
      join
      wait_pulses("t2_pulses", 3, 40);
      chk("t2_stalled", 32'(stalls > 0), 32'd1);

      // 4: reset with one bank full and the other half filled
      do_reset();
      bus.request = 1'b0;
      for (int i = 0; i < 144; i++) send(8'(i + 100), 1'b0);
      @(posedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      chk("t4_ready", 32'(bus.ready), 32'd0);
      chk("t4_o_data_zero", 32'(bus.o_data != '0), 32'd0);
      chk("t4_stall", 32'(bus.stall_cnt), 32'd0);
      chk("t4_s_ready", 32'(bus.s_ready), 32'd1);
      base = pulses;
      bus.request = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("t4_no_pulse", pulses, base);
      for (int i = 0; i < PN; i++) send(8'(3 * i + 1), 1'b0);
      wait_pulses("t4_pulses", base + 1, 20);

      // 3: SOF discards a partial fill
      base = pulses;
      for (int i = 0; i < 40; i++) send(8'h11, 1'b0);
      send(8'hAA, 1'b1);
      for (int i = 0; i < 95; i++) send(8'(2 * (i + 1)), 1'b0);
      wait_pulses("t3_pulses", base + 1, 20);
      chk("t3_slot0", 32'(bus.o_data[7:0]), 32'hAA);
      chk("t3_slot1", 32'(bus.o_data[15:8]), 32'h02);
      chk("t3_slot95", 32'(bus.o_data[95*8 +: 8]), 32'hBE);

      // 5: continuous read/write overlap over five words
      base = pulses;
      for (int i = 0; i < 5 * PN; i++) send(8'(7 * i + 3), 1'b0);
      wait_pulses("t5_pulses", base + 5, 20);
      chk("t5_queue_empty", exp_q.size(), 0);

      // 6: stall counter with both banks full
      do_reset();
      bus.request = 1'b0;
      for (int i = 0; i < 192; i++) send(8'(i + 9), 1'b0);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'hEE;
      repeat (10) @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
`ifdef PIXEL_PACKER_STATS_EN
      chk("t6_stall_cnt", 32'(bus.stall_cnt), 32'd10);
`else
      chk("t6_stall_cnt", 32'(bus.stall_cnt), 32'd0);
`endif
      base = pulses;
      bus.request = 1'b1;
      wait_pulses("t6_drain", base + 2, 20);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
